// File: rtl/neuron_mac_param.sv
// Sequential single-MAC neuron: bias + sum(x[k]*w[k] >>> FRAC_BITS), then ReLU, with a valid/ready handshake on both sides.
// Define NEURON_MAC_SAT_EN to clamp positive results; without it, y is the accumulator's low bits.
module neuron_mac_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int N_INPUTS   = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N_INPUTS) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] x_flat,
  input  logic                           w_wr_en,
  input  logic [$clog2(N_INPUTS+1)-1:0]  w_wr_addr,
  input  logic [DATA_WIDTH-1:0]          w_wr_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          y,
  output logic                           busy
);

  localparam int KW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int AW = $clog2(N_INPUTS+1);
  localparam logic [KW-1:0] KLAST = KW'(N_INPUTS-1);

  typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

  state_t                          state_q;
  logic [KW-1:0]                   k_q;
  logic signed [ACC_WIDTH-1:0]     acc_q;
  logic [N_INPUTS*DATA_WIDTH-1:0]  x_q;
  logic [DATA_WIDTH-1:0]           w_q [N_INPUTS];
  logic [DATA_WIDTH-1:0]           bias_q;
  logic [DATA_WIDTH-1:0]           y_q;
  logic                            outValid_q;

  logic signed [DATA_WIDTH-1:0]    xk, wk;
  logic signed [2*DATA_WIDTH-1:0]  prod, prodSh;
  logic signed [ACC_WIDTH-1:0]     macTerm_d;
  logic [DATA_WIDTH-1:0]           biasSel;
  logic signed [ACC_WIDTH-1:0]     biasExt_d;
  logic [DATA_WIDTH-1:0]           y_d;

  assign in_ready  = en && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = outValid_q;
  assign y         = y_q;

  // Product term for channel k; arithmetic shift floors toward minus infinity.
  always_comb begin
    xk = '0;
    wk = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (k_q == KW'(i)) begin
        xk = x_q[i*DATA_WIDTH +: DATA_WIDTH];
        wk = w_q[i];
      end
    end
    prod      = xk * wk;
    prodSh    = prod >>> FRAC_BITS;
    macTerm_d = {{(ACC_WIDTH-2*DATA_WIDTH){prodSh[2*DATA_WIDTH-1]}}, prodSh};
  end

  // A bias written on the accept edge must already seed this job's accumulator.
  always_comb begin
    biasSel   = (w_wr_en && (w_wr_addr == AW'(N_INPUTS))) ? w_wr_data : bias_q;
    biasExt_d = {{(ACC_WIDTH-DATA_WIDTH){biasSel[DATA_WIDTH-1]}}, biasSel};
  end

  always_comb begin
    y_d = acc_q[DATA_WIDTH-1:0];
`ifdef NEURON_MAC_SAT_EN
    if (|acc_q[ACC_WIDTH-2:DATA_WIDTH-1]) y_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
    if (acc_q[ACC_WIDTH-1] || (acc_q == '0)) y_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      acc_q      <= '0;
      x_q        <= '0;
      bias_q     <= '0;
      y_q        <= '0;
      outValid_q <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
    end else if (en) begin
      if ((state_q == IDLE) && w_wr_en) begin
        for (int i = 0; i < N_INPUTS; i++) begin
          if (w_wr_addr == AW'(i)) w_q[i] <= w_wr_data;
        end
        if (w_wr_addr == AW'(N_INPUTS)) bias_q <= w_wr_data;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= x_flat;
            acc_q   <= biasExt_d;
            k_q     <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + macTerm_d;
          if (k_q == KLAST) begin
            k_q     <= '0;
            state_q <= ACT;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        ACT: begin
          y_q        <= y_d;
          outValid_q <= 1'b1;
          state_q    <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
